// File: rtl/mult32x32_pkg.sv
// mult32x32_pkg: shared state type and partial-product shift encodings for the 32x32 multiplier
package mult32x32_pkg;
  typedef enum logic [2:0] {IDLE, A0B0, A0B1, A1B0, A1B1} state_t;
  localparam logic [1:0] SHIFT_0 = 2'd0;
  localparam logic [1:0] SHIFT_16 = 2'd1;
  localparam logic [1:0] SHIFT_32 = 2'd2;
endpackage

// File: rtl/mult32x32_fast_fsm.sv
// mult32x32_fast_fsm: sequencer for a 16x16-based 32x32 multiplier that skips partial products of zero halves
module mult32x32_fast_fsm
  import mult32x32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msw_is_0,
  input  logic       b_msw_is_0,
  output logic       busy,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod
);
  state_t state_q, state_d;
  always_ff @(posedge clk)
    state_q <= !reset ? IDLE : state_d;
  always_comb begin
    state_d = IDLE;
    busy = 1'b1;
    upd_prod = 1'b1;
    clr_prod = 1'b0;
    a_sel = 1'b0;
    b_sel = 1'b0;
    shift_sel = SHIFT_0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        upd_prod = 1'b0;
        clr_prod = start;
        state_d = start ? A0B0 : IDLE;
      end
      A0B0: state_d = (a_msw_is_0 && b_msw_is_0) ? IDLE : b_msw_is_0 ? A1B0 : A0B1;
      A0B1: begin
        b_sel = 1'b1;
        shift_sel = SHIFT_16;
        state_d = a_msw_is_0 ? IDLE : A1B0;
      end
      A1B0: begin
        a_sel = 1'b1;
        shift_sel = SHIFT_16;
        state_d = b_msw_is_0 ? IDLE : A1B1;
      end
      A1B1: begin
        a_sel = 1'b1;
        b_sel = 1'b1;
        shift_sel = SHIFT_32;
      end
      default: begin
        busy = 1'b0;
        upd_prod = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// tb_mult32x32_fast_fsm: drives the sequencer with a behavioural product register and checks
// step sequence, busy length and final product against plain 64-bit multiplication.
module tb_mult32x32_fast_fsm;
  logic clk = 0, reset = 0, start = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, a_sel, b_sel, upd_prod, clr_prod;
  logic [1:0] shift_sel;
  logic [63:0] prod, pp;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mult32x32_fast_fsm dut (
    .clk(clk), .reset(reset), .start(start),
    .a_msw_is_0(a[31:16] == 16'd0), .b_msw_is_0(b[31:16] == 16'd0),
    .busy(busy), .a_sel(a_sel), .b_sel(b_sel), .shift_sel(shift_sel),
    .upd_prod(upd_prod), .clr_prod(clr_prod)
  );

  // stand-in for the arithmetic unit, steered only by the controls
  assign pp = (64'(a_sel ? a[31:16] : a[15:0]) * 64'(b_sel ? b[31:16] : b[15:0])) << (7'(shift_sel) * 7'd16);
  always @(posedge clk)
    if (clr_prod) prod <= 64'd0;
    else if (upd_prod) prod <= prod + pp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // called at #1 into an idle cycle; returns at #1 into the first idle cycle after busy
  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic hold);
    logic [3:0] exp_seq[$];
    int n;
    exp_seq = {4'b0000};
    if (bv[31:16] != 0) exp_seq.push_back(4'b0101);
    if (av[31:16] != 0) exp_seq.push_back(4'b1001);
    if (av[31:16] != 0 && bv[31:16] != 0) exp_seq.push_back(4'b1110);
    a = av; b = bv; start = 1;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_clr", 64'(clr_prod), 64'd1);
    @(posedge clk); #1;
    start = hold;
    n = 0;
    while (busy && n < 8) begin
      if (n < exp_seq.size()) chk("step", 64'({a_sel, b_sel, shift_sel}), 64'(exp_seq[n]));
      chk("busy_ctl", 64'({upd_prod, clr_prod}), 64'b10);
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", 64'(n), 64'(exp_seq.size()));
    chk("product", prod, 64'(av) * 64'(bv));
    chk("done_upd", 64'(upd_prod), 64'd0);
    chk("done_clr", 64'(clr_prod), 64'(hold));
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 0; start = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'({busy, upd_prod, a_sel, b_sel, shift_sel}), 64'd0);
    chk("rst_clr_start", 64'(clr_prod), 64'd1);
    start = 0; #1;
    chk("rst_clr_nostart", 64'(clr_prod), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    op(32'h0000_1234, 32'h0000_5678, 0);
    chk("req33", prod, 64'h0000_0000_0626_0060);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("req34", prod, 64'hFFFF_FFFE_0000_0001);
    op(32'h0000_0002, 32'h0003_0000, 0);
    chk("req35", prod, 64'h0000_0000_0006_0000);
    op(32'h0001_0000, 32'h0000_0005, 0);
    chk("req36", prod, 64'h0000_0000_0005_0000);
    // reset in the 2nd busy cycle of a full-length operation
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_upd", 64'(upd_prod), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    op(32'hDEAD_BEEF, 32'h1234_5678, 0);
    // start held high: each op chains straight into the next from its first idle cycle
    op(32'hFFFF_FFFF, 32'h0000_FFFF, 1);
    op(32'h0000_00FF, 32'hABCD_0001, 1);
    op(32'h8000_0000, 32'h8000_0000, 0);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 2) == 0) ra[31:16] = 0;
      if ($urandom_range(0, 2) == 0) rb[31:16] = 0;
      if ($urandom_range(0, 5) == 0) ra[15:0] = 0;
      op(ra, rb, 1'($urandom_range(0, 1)));
    end
    start = 0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
